// File: rtl/shift_src_pkg.sv
// Shared definitions for the shift_src_reg operand shifter.
// Op codes, FSM state encoding and LFSR tap positions.
package shift_src_pkg;

   localparam int WIDTH_DEF = 8;

   localparam logic [2:0] OP_CLR  = 3'd0;
   localparam logic [2:0] OP_LOAD = 3'd1;
   localparam logic [2:0] OP_SRL  = 3'd2;
   localparam logic [2:0] OP_SLL  = 3'd3;
   localparam logic [2:0] OP_SRA  = 3'd4;
   localparam logic [2:0] OP_ROR  = 3'd5;
   localparam logic [2:0] OP_SIN  = 3'd6;
   localparam logic [2:0] OP_LFSR = 3'd7;

   localparam int LFSR_TAP0 = 4;
   localparam int LFSR_TAP1 = 3;
   localparam int LFSR_TAP2 = 2;
   localparam int LFSR_TAP3 = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   function automatic logic is_single_step(input logic [2:0] op);
      return (op == OP_CLR) || (op == OP_LOAD);
   endfunction

endpackage

// File: rtl/shift_src_step.sv
// One single-bit step of the operand shifter.
// Purely combinational: (op, r, data, ser, SEED) -> next r.
module shift_src_step
   import shift_src_pkg::*;
#(
   parameter int               WIDTH = WIDTH_DEF,
   parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_r,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ser,
   output logic [WIDTH-1:0] o_next
);

   logic w_fb;

   assign w_fb = i_r[LFSR_TAP0] ^ i_r[LFSR_TAP1]
               ^ i_r[LFSR_TAP2] ^ i_r[LFSR_TAP3];

   always_comb begin
      o_next = i_r;
      unique case (i_op)
         OP_CLR:  o_next = '0;
         OP_LOAD: o_next = i_data;
         OP_SRL:  o_next = {1'b0, i_r[WIDTH-1:1]};
         OP_SLL:  o_next = {i_r[WIDTH-2:0], 1'b0};
         OP_SRA:  o_next = {i_r[WIDTH-1], i_r[WIDTH-1:1]};
         OP_ROR:  o_next = {i_r[0], i_r[WIDTH-1:1]};
         OP_SIN:  o_next = {i_ser, i_r[WIDTH-1:1]};
         // An all-zero register would lock the LFSR, so reseed instead.
         OP_LFSR: o_next = (i_r == '0) ? SEED : {w_fb, i_r[WIDTH-1:1]};
         default: o_next = i_r;
      endcase
   end

endmodule

// File: rtl/shift_src_reg.sv
// Multi-mode shift register feeding the barrel shifter datapath.
// One command per handshake, k single-bit steps, result held on out port.
module shift_src_reg
   import shift_src_pkg::*;
#(
   parameter int               WIDTH = WIDTH_DEF,
   parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_ser,
   input  logic [2:0]       cmd_cnt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_data;
   logic             r_ser;
   logic [2:0]       r_cnt;
   logic [WIDTH-1:0] r_reg;
   logic [WIDTH-1:0] w_next;
   logic             w_accept;

   shift_src_step #(
      .WIDTH (WIDTH),
      .SEED  (SEED)
   ) u_step (
      .i_op   (r_op),
      .i_r    (r_reg),
      .i_data (r_data),
      .i_ser  (r_ser),
      .o_next (w_next)
   );

   assign w_accept = (r_state == ST_IDLE) && cmd_valid;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (cmd_valid)      w_state_nxt = ST_RUN;
         ST_RUN:  if (r_cnt == 3'd0)  w_state_nxt = ST_OUT;
         ST_OUT:  if (out_ready)      w_state_nxt = ST_IDLE;
         default:                     w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_op    <= OP_CLR;
         r_data  <= '0;
         r_ser   <= 1'b0;
         r_cnt   <= 3'd0;
         r_reg   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op   <= cmd_op;
            r_data <= cmd_data;
            r_ser  <= cmd_ser;
            // CLR and LOAD always take exactly one step.
            r_cnt  <= is_single_step(cmd_op) ? 3'd0 : cmd_cnt;
         end else if (r_state == ST_RUN) begin
            r_reg <= w_next;
            r_cnt <= r_cnt - 3'd1;
         end
      end
   end

   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign out_valid = (r_state == ST_OUT);
   assign out_data  = r_reg;

endmodule
